// File: rtl/clz_normalizer.sv
// Iterative CLZ/CLO counter and left-normalizer: recovers the shift that normalizes din.
// Define FAST_SKIP_EN to retire four leading zeros per edge when the top nibble is clear.
module clz_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] norm,
  output logic [1:0]       dbg_state
);

  // Handshake: start is honoured only in IDLE; busy is high for every SCAN
  // cycle; done is a one-cycle pulse in DONE, when count/norm already hold
  // the new result. Starts seen during busy or done are dropped, not queued.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [WIDTH-1:0] s, s_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] count_n;
  logic [WIDTH-1:0] norm_n;
  logic             scan_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      s     <= '0;
      cnt   <= '0;
      count <= '0;
      norm  <= '0;
    end else begin
      state <= state_n;
      r     <= r_n;
      s     <= s_n;
      cnt   <= cnt_n;
      count <= count_n;
      norm  <= norm_n;
    end
  end

  // Both modes reduce to a leading-zero scan of r; s carries the untouched operand.
  assign scan_end = r[WIDTH-1] || (cnt == CNT_W'(WIDTH));

  always_comb begin
    state_n = state;
    r_n     = r;
    s_n     = s;
    cnt_n   = cnt;
    count_n = count;
    norm_n  = norm;
    case (state)
      IDLE: begin
        if (start) begin
          r_n     = din ^ {WIDTH{mode}};
          s_n     = din;
          cnt_n   = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (scan_end) begin
          count_n = cnt;
          norm_n  = s;
          state_n = DONE;
        end
`ifdef FAST_SKIP_EN
        else if ((r[WIDTH-1 -: 4] == 4'b0000) && (cnt <= CNT_W'(WIDTH - 4))) begin
          r_n   = r << 4;
          s_n   = s << 4;
          cnt_n = cnt + CNT_W'(4);
        end
`endif
        else begin
          r_n   = r << 1;
          s_n   = s << 1;
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_clz_normalizer.sv
// Scoreboard bench for clz_normalizer: random and directed CLZ/CLO operations
// checked for result, latency, busy length, output hold and ignored starts.
module tb_clz_normalizer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int EW    = CNT_W + WIDTH;
`ifdef FAST_SKIP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] norm;
  logic [1:0]       dbg_state;

  clz_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .din(din),
    .busy(busy), .done(done), .count(count), .norm(norm), .dbg_state(dbg_state)
  );

  // clock / reset block
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [EW-1:0]    exp_q[$];
  int               edge_q[$];
  int               lat_q[$];
  int               checks = 0;
  int               errors = 0;
  int               busy_cnt = 0;
  logic [CNT_W-1:0] hold_count = '0;
  logic [WIDTH-1:0] hold_norm = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: count leading bits equal to mode, then shift out
  function automatic int model_n(input logic [WIDTH-1:0] d, input logic m);
    int  n = 0;
    bit  run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (run && d[i] == m) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic int model_lat(input int n);
    return FAST ? (n / 4 + n % 4 + 1) : (n + 1);
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic m, input int accept,
                          output int done_edge);
    int n;
    logic [WIDTH-1:0] nv;
    n  = model_n(d, m);
    nv = (n >= WIDTH) ? '0 : (d << n);
    exp_q.push_back({CNT_W'(n), nv});
    lat_q.push_back(model_lat(n));
    done_edge = accept + model_lat(n);
    edge_q.push_back(done_edge);
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          logic [EW-1:0] e;
          int eedge, elat;
          e     = exp_q.pop_front();
          eedge = edge_q.pop_front();
          elat  = lat_q.pop_front();
          chk("count", 64'(count), 64'(e[EW-1:WIDTH]));
          chk("norm", 64'(norm), 64'(e[WIDTH-1:0]));
          chk("done_edge", 64'(cyc), 64'(eedge));
          chk("busy_cycles", 64'(busy_cnt), 64'(elat));
          hold_count = e[EW-1:WIDTH];
          hold_norm  = e[WIDTH-1:0];
        end
        busy_cnt = 0;
      end else begin
        chk("hold_count", 64'(count), 64'(hold_count));
        chk("hold_norm", 64'(norm), 64'(hold_norm));
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] d, input logic m, input bit noise);
    int accept, d_edge;
    wait_idle();
    start  = 1'b1;
    din    = d;
    mode   = m;
    accept = cyc + 1;
    push_exp(d, m, accept, d_edge);
    @(negedge clk);
    while (cyc <= d_edge) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        din   = $urandom;
        mode  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic hold_run(input logic [WIDTH-1:0] d, input logic m, input int ops);
    int accept, d_edge;
    wait_idle();
    start  = 1'b1;
    din    = d;
    mode   = m;
    accept = cyc + 1;
    d_edge = accept;
    for (int i = 0; i < ops; i++) begin
      push_exp(d, m, accept, d_edge);
      accept = d_edge + 2;
    end
    while (cyc < d_edge) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    edge_q.delete();
    lat_q.delete();
    hold_count = '0;
    hold_norm  = '0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_norm", 64'(norm), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_done_hold", 64'(done), 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] x;
    logic             m;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    apply_reset();

    // abort mid-operation, then a clean restart
    wait_idle();
    start = 1'b1;
    din   = 32'h0000_0001;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    apply_reset();
    issue(32'h0000_0001, 1'b0, 1'b0);

    issue(32'h0000_8000, 1'b0, 1'b0);
    issue(32'h0000_0000, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'hFFF0_1234, 1'b1, 1'b0);
    issue(32'h8000_0000, 1'b0, 1'b0);
    issue(32'h7FFF_FFFF, 1'b1, 1'b0);
    hold_run(32'h0000_0100, 1'b0, 3);
    issue(32'h0F00_0000, 1'b0, 1'b1);
    issue(32'h0000_0003, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      x = $urandom >> $urandom_range(0, 32);
      if (m) x = ~x;
      issue(x, m, 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_pending", 64'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clz_normalizer.md
Name: clz_normalizer

Overview:
- Iterative leading-zero/leading-one counter and left-normalizer for the MIPS32 CLZ/CLO instructions in the pipelined CPU.
- Performs the inverse of the shift unit: given a data word, it recovers the left-shift amount that normalizes it and produces the normalized word.
- Multi-cycle execute-stage unit with a start/busy/done handshake; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, data width in bits.
- CNT_W, 6, width of count output; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
- din  input  WIDTH  operand; sampled with start.
- busy  output  1  high in SCAN state.
- done  output  1  one-cycle pulse, high only in DONE state.
- count  output  CNT_W  leading-bit count N, range 0..WIDTH.
- norm  output  WIDTH  din shifted left by N, zero-filled.

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, count=0, norm=0; all internal registers cleared. Reset asserted mid-operation aborts the operation immediately and produces no done.
- Working register R = din XOR {WIDTH{mode}}, so both modes reduce to counting leading zeros of R. Shadow register S = din.
- IDLE:
  - start=1 at an edge: load R, S, cnt=0 (cnt is CNT_W wide), latch mode, then go to SCAN.
  - start=0: stay in IDLE.
- SCAN, one decision per edge:
  - If R[WIDTH-1]=1 or cnt==WIDTH, go to DONE.
  - Otherwise R<<=1, S<<=1 (zero-fill), cnt+=1.
- DONE:
  - done=1 for exactly one cycle; count<=cnt, norm<=S (registered on the SCAN->DONE edge).
  - Return to IDLE on the next edge.
- Output hold: count and norm hold their values from the last completed operation until the next SCAN->DONE edge. They do not change during SCAN.
- Latency: with N = result, done is high in the cycle after the (N+1)th rising edge following the edge that sampled start. Worst case is din=0 (CLZ) or all-ones (CLO): N=WIDTH, 33 edges.
- Ignored starts:
  - start while busy=1 is ignored (not queued).
  - start while done=1 is ignored; the caller must re-assert start in IDLE.
- Boundary cases:
  - din[31] already differs from the mode bit: N=0, done after 1 edge, norm=din.
  - cnt never exceeds WIDTH.
  - mode and din changes after the start edge have no effect on the operation.

Optional Feature:
- Macro FAST_SKIP_EN.
- Defined:
  - In SCAN, if R[WIDTH-1:WIDTH-4]==0 and cnt<=WIDTH-4, shift R and S by 4 and add 4 to cnt in one edge.
  - Otherwise the single-bit rule applies.
  - Termination conditions are unchanged.
  - Latency = floor(N/4) + (N mod 4) + 1 edges; din=0 takes 9 edges.
  - Results are identical to the undefined case.
- Undefined: single-bit step only, latency N+1 edges.

Test Plan:
- Reset mid-op: start with din=32'h0000_0001, mode=0; assert reset after 5 edges -> busy=0, done never pulses, count=0, norm=0; a new start afterwards completes normally with count=31.
- CLZ basic: din=32'h0000_8000, mode=0 -> count=16, norm=32'h8000_0000; done after 17 edges (FAST_SKIP_EN: 5 edges); busy high for exactly the SCAN cycles.
- CLZ zero: din=32'h0, mode=0 -> count=32, norm=32'h0; done after 33 edges (FAST_SKIP_EN: 9).
- CLO and N=0:
  - din=32'hFFF0_1234, mode=1 -> count=12, norm=32'h0123_4000.
  - din=32'h8000_0000, mode=0 -> count=0, norm=32'h8000_0000, done after 1 edge.
- Handshake:
  - start held high continuously with din=32'h0000_0100, mode=0: each operation yields count=23.
  - start during busy or during the done cycle is ignored; each accepted op produces exactly one done pulse.
  - count/norm remain stable while the next op is busy.
- Back-to-back: op1 din=32'h0F00_0000 (count=4), op2 din=32'h0000_0003 (count=30) issued in the first IDLE cycle after done -> outputs update only at each DONE; mode change mid-op has no effect.
